// File: rtl/ex_alu_stage.sv
// ex_alu_stage: execute stage of the 8-bit pipelined processor.
// It takes the operands, opcode and RegWrite held in ID/EX and produces the
// registered result, opcode, RegWrite, valid and zero flag that EX/WB latches.
//
// Build option: EX_MUL_EN
//   defined   - opcode 110 is a multi-cycle shift-add multiply. The stage
//               raises stall while busy and emits bubbles until done.
//   undefined - opcode 110 is a single-cycle logical shift right.
//               stall is tied low and no multiplier logic is built.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   op_a, op_b           operands from ID/EX
//   instr_code_in        3-bit opcode from ID/EX
//   reg_write_in         RegWrite from ID/EX
//   valid_in             ID/EX holds a real instruction
//   stall                ID/EX must hold its contents (combinational)
//   alu_result           registered result to EX/WB
//   instr_code_out       registered opcode to EX/WB
//   reg_write_out        registered RegWrite to EX/WB
//   valid_out            registered; result is a real instruction
//   zero_flag            registered; alu_result==0 for a valid result
module ex_alu_stage #(
  parameter int DATA_W     = 8,
  parameter int MUL_CYCLES = DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [2:0]        instr_code_in,
  input  logic              reg_write_in,
  input  logic              valid_in,
  output logic              stall,
  output logic [DATA_W-1:0] alu_result,
  output logic [2:0]        instr_code_out,
  output logic              reg_write_out,
  output logic              valid_out,
  output logic              zero_flag
);

  localparam int SH_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;  // SRL when the multiplier is not built
  localparam logic [2:0] OP_NOP = 3'b111;

  // Only the low bits of op_b count as a shift amount.
  logic [SH_W-1:0]   w_shamt;
  logic [DATA_W-1:0] w_alu;

  assign w_shamt = op_b[SH_W-1:0];

  always_comb begin
    w_alu = '0;
    case (instr_code_in)
      OP_ADD: w_alu = op_a + op_b;
      OP_SUB: w_alu = op_a - op_b;
      OP_AND: w_alu = op_a & op_b;
      OP_OR:  w_alu = op_a | op_b;
      OP_XOR: w_alu = op_a ^ op_b;
      OP_SHL: w_alu = op_a << w_shamt;
`ifndef EX_MUL_EN
      OP_MUL: w_alu = op_a >> w_shamt;
`endif
      default: w_alu = '0;  // NOP (and MUL, which never uses this path)
    endcase
  end

`ifdef EX_MUL_EN
  localparam int CNT_W = $clog2(MUL_CYCLES + 1);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_mcand, r_mplier, r_acc;
  logic [2:0]        r_code;
  logic              r_rw;
  logic              w_mul_last;
  logic [DATA_W-1:0] w_acc_nxt;

  // Only the low DATA_W product bits are kept, so the multiplicand can
  // shift out of its register without loss.
  assign w_mul_last = (r_cnt == CNT_W'(MUL_CYCLES - 1));
  assign w_acc_nxt  = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign stall      = (r_state == S_MUL);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (valid_in && instr_code_in == OP_MUL) w_state_nxt = S_MUL;
      S_MUL:  if (w_mul_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end
`else
  assign stall = 1'b0;
  logic w_unused_mul_cfg;
  assign w_unused_mul_cfg = (MUL_CYCLES > 0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_result     <= '0;
      instr_code_out <= 3'b000;
      reg_write_out  <= 1'b0;
      valid_out      <= 1'b0;
      zero_flag      <= 1'b0;
`ifdef EX_MUL_EN
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_code   <= 3'b000;
      r_rw     <= 1'b0;
`endif
    end else begin
      // Bubble unless a result completes below; result/code hold.
      valid_out     <= 1'b0;
      reg_write_out <= 1'b0;
      zero_flag     <= 1'b0;
`ifdef EX_MUL_EN
      if (r_state == S_MUL) begin
        r_acc    <= w_acc_nxt;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + 1'b1;
        if (w_mul_last) begin
          alu_result     <= w_acc_nxt;
          instr_code_out <= r_code;
          reg_write_out  <= r_rw;
          valid_out      <= 1'b1;
          zero_flag      <= (w_acc_nxt == '0);
        end
      end else if (valid_in && instr_code_in == OP_MUL) begin
        r_mcand  <= op_a;
        r_mplier <= op_b;
        r_acc    <= '0;
        r_cnt    <= '0;
        r_code   <= instr_code_in;
        r_rw     <= reg_write_in;
      end else
`endif
      if (valid_in) begin
        alu_result     <= w_alu;
        instr_code_out <= instr_code_in;
        reg_write_out  <= (instr_code_in == OP_NOP) ? 1'b0 : reg_write_in;
        valid_out      <= 1'b1;
        zero_flag      <= (w_alu == '0);
      end
    end
  end

endmodule

// File: tb/tb_ex_alu_stage.sv
// Self-checking bench for ex_alu_stage. Stimulus pushes the hand-computed
// expected response into a queue; a monitor pops and compares on every
// cycle the DUT presents valid_out.
module tb_ex_alu_stage;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] op_a, op_b;
  logic [2:0] instr_code_in;
  logic       reg_write_in, valid_in;
  logic       stall;
  logic [7:0] alu_result;
  logic [2:0] instr_code_out;
  logic       reg_write_out, valid_out, zero_flag;

  always #5 clk = ~clk;

  ex_alu_stage #(.DATA_W(8), .MUL_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .op_a(op_a), .op_b(op_b),
    .instr_code_in(instr_code_in), .reg_write_in(reg_write_in),
    .valid_in(valid_in), .stall(stall), .alu_result(alu_result),
    .instr_code_out(instr_code_out), .reg_write_out(reg_write_out),
    .valid_out(valid_out), .zero_flag(zero_flag)
  );

  typedef struct packed {
    logic [7:0] res;
    logic [2:0] code;
    logic       rw;
    logic       z;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  logic stall_seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every valid output must match the oldest expected entry.
  always @(negedge clk) begin
    if (stall === 1'b1) stall_seen = 1'b1;
    if (valid_out === 1'b1) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_out: got res=0x%0h code=%0d rw=%0d z=%0d with nothing expected",
                 alu_result, instr_code_out, reg_write_out, zero_flag);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("result", {19'd0, alu_result, instr_code_out, reg_write_out, zero_flag},
            {19'd0, e.res, e.code, e.rw, e.z});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] c, input logic [7:0] a, input logic [7:0] b,
                       input logic rw, input logic v);
    instr_code_in = c; op_a = a; op_b = b; reg_write_in = rw; valid_in = v;
  endtask

  // Issue a single-cycle op and record what must come out one edge later.
  task automatic issue(input logic [2:0] c, input logic [7:0] a, input logic [7:0] b,
                       input logic rw, input logic [7:0] res, input logic rw_o);
    exp_t e;
    drive(c, a, b, rw, 1'b1);
    e.res = res; e.code = c; e.rw = rw_o; e.z = (res == 8'h00);
    q.push_back(e);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   n;
    reset = 1'b1;
    drive(3'b000, 8'h00, 8'h00, 1'b0, 1'b0);
    step(); step();
    reset = 1'b0;
    chk("reset_outs", {alu_result, instr_code_out, reg_write_out, valid_out, zero_flag}, 14'd0);
    chk("reset_stall", {31'd0, stall}, 0);

    issue(3'b000, 8'hF0, 8'h20, 1'b1, 8'h10, 1'b1);  // ADD
    issue(3'b001, 8'h05, 8'h07, 1'b1, 8'hFE, 1'b1);  // SUB wrap
    issue(3'b001, 8'h33, 8'h33, 1'b1, 8'h00, 1'b1);  // SUB zero
    issue(3'b101, 8'h81, 8'h09, 1'b1, 8'h02, 1'b1);  // SHL, upper b ignored
    issue(3'b111, 8'h55, 8'hAA, 1'b1, 8'h00, 1'b0);  // NOP forces rw=0
    issue(3'b000, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b0);  // ADD carry discarded
    issue(3'b010, 8'hF0, 8'h3C, 1'b1, 8'h30, 1'b1);  // AND
    issue(3'b011, 8'h0F, 8'h30, 1'b0, 8'h3F, 1'b0);  // OR
    issue(3'b100, 8'hFF, 8'h0F, 1'b1, 8'hF0, 1'b1);  // XOR

    // Bubble: result and code hold, flags drop.
    drive(3'b000, 8'h01, 8'h01, 1'b1, 1'b0);
    step();
    chk("bubble", {alu_result, instr_code_out, reg_write_out, valid_out, zero_flag},
        {8'hF0, 3'b100, 3'b000});

`ifdef EX_MUL_EN
    // MUL 0x0D*0x13 = 0xF7, followed by ADD held upstream during stall.
    drive(3'b110, 8'h0D, 8'h13, 1'b1, 1'b1);
    e.res = 8'hF7; e.code = 3'b110; e.rw = 1'b1; e.z = 1'b0;
    q.push_back(e);
    step();
    drive(3'b000, 8'h01, 8'h01, 1'b1, 1'b1);
    e.res = 8'h02; e.code = 3'b000; e.rw = 1'b1; e.z = 1'b0;
    q.push_back(e);
    n = 0;
    while (stall === 1'b1 && n < 20) begin
      chk("busy_valid", {31'd0, valid_out}, 0);
      step();
      n++;
    end
    chk("stall_cycles", n, 8);
    step();  // held ADD accepted here
    drive(3'b000, 8'h00, 8'h00, 1'b0, 1'b0);
    step();

    // Abort: reset during third busy cycle, no product ever emitted.
    drive(3'b110, 8'h0D, 8'h13, 1'b1, 1'b1);
    step();               // busy cycle 1
    drive(3'b000, 8'h00, 8'h00, 1'b0, 1'b0);
    step();               // busy cycle 2
    step();               // busy cycle 3
    chk("abort_busy", {31'd0, stall}, 1);
    reset = 1'b1;
    step();
    chk("abort_outs", {alu_result, instr_code_out, reg_write_out, valid_out, zero_flag}, 14'd0);
    reset = 1'b0;
    step();
    chk("abort_stall", {31'd0, stall}, 0);
    repeat (12) step();
`else
    // Opcode 110 is SRL without the multiplier.
    issue(3'b110, 8'h80, 8'h03, 1'b1, 8'h10, 1'b1);
    issue(3'b110, 8'hFF, 8'h0F, 1'b0, 8'h01, 1'b0);  // amount 7
    drive(3'b000, 8'h00, 8'h00, 1'b0, 1'b0);
    step();
`endif

    @(negedge clk);
    #1;
`ifndef EX_MUL_EN
    chk("stall_never", {31'd0, stall_seen}, 0);
`endif
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
